// File: rtl/semaforo_pkg.sv
// ============================================================================
// Module      : semaforo_pkg
// Description : Light codes, state encoding and default phase times shared by
//               the semaforo_ctrl intersection controller.
//               Optional build macro: SEMAFORO_NIGHT_BLINK_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package semaforo_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_T_GREEN  = 30;
  localparam int DEF_T_YELLOW = 4;
  localparam int DEF_T_ALLRED = 2;
  localparam int DEF_T_AUX    = 15;

  typedef enum logic [2:0] {
    S_OFF         = 3'd0,
    S_MAIN_GREEN  = 3'd1,
    S_MAIN_YELLOW = 3'd2,
    S_ALL_RED1    = 3'd3,
    S_AUX_GREEN   = 3'd4,
    S_ALL_RED2    = 3'd5
`ifdef SEMAFORO_NIGHT_BLINK_EN
    ,S_BLINK      = 3'd6
`endif
  } state_e;

  // States whose duration is measured by the phase timer.
  function automatic logic is_timed(input state_e s);
    return (s == S_MAIN_GREEN) || (s == S_MAIN_YELLOW) || (s == S_ALL_RED1) ||
           (s == S_AUX_GREEN)  || (s == S_ALL_RED2);
  endfunction

endpackage : semaforo_pkg

`default_nettype wire

// File: rtl/semaforo_timer.sv
// ============================================================================
// Module      : semaforo_timer
// Description : CNT_W-wide phase down-counter; done flags a tick seen at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module semaforo_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so a held phase keeps reporting done on every tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = tick && (cnt_q == '0);

endmodule : semaforo_timer

`default_nettype wire

// File: rtl/semaforo_ctrl.sv
// ============================================================================
// Module      : semaforo_ctrl
// Description : Timed, demand-actuated Moore controller for one intersection.
//               Optional build macro: SEMAFORO_NIGHT_BLINK_EN (adds night input
//               and a flashing-yellow state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_AUX    = DEF_T_AUX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       tick,
  input  logic       ped_req,
`ifdef SEMAFORO_NIGHT_BLINK_EN
  input  logic       night,
`endif
  output logic [1:0] light_main,
  output logic [1:0] light_aux,
  output logic       ped_wait
);

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_AUX    = CNT_W'(T_AUX - 1);

  state_e           state_q;
  state_e           state_d;
  logic             ped_pending_q;
  logic             ped_pending_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             timer_tick;
  logic             done;
  logic             run;

`ifdef SEMAFORO_NIGHT_BLINK_EN
  logic blink_q;
  logic blink_d;
  assign run = en && !night;
`else
  assign run = en;
`endif

  // The timer only advances while a timed phase is actually running.
  assign timer_tick = tick && run && is_timed(state_q);

  semaforo_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (timer_tick),
    .done     (done)
  );

  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    load_val      = LD_ALLRED;
    ped_pending_d = ped_pending_q | ped_req;
    if (!en) begin
      state_d       = S_OFF;
      ped_pending_d = 1'b0;
    end
`ifdef SEMAFORO_NIGHT_BLINK_EN
    else if (night) begin
      state_d       = S_BLINK;
      ped_pending_d = 1'b0;
    end
`endif
    else begin
      case (state_q)
        S_OFF: begin
          state_d  = S_ALL_RED2;
          load     = 1'b1;
          load_val = LD_ALLRED;
        end
        S_MAIN_GREEN: begin
          if (done && ped_pending_q) begin
            state_d  = S_MAIN_YELLOW;
            load     = 1'b1;
            load_val = LD_YELLOW;
          end
        end
        S_MAIN_YELLOW: begin
          if (done) begin
            state_d  = S_ALL_RED1;
            load     = 1'b1;
            load_val = LD_ALLRED;
          end
        end
        S_ALL_RED1: begin
          if (done) begin
            state_d       = S_AUX_GREEN;
            load          = 1'b1;
            load_val      = LD_AUX;
            ped_pending_d = 1'b0;
          end
        end
        S_AUX_GREEN: begin
          if (done) begin
            state_d  = S_ALL_RED2;
            load     = 1'b1;
            load_val = LD_ALLRED;
          end
        end
        S_ALL_RED2: begin
          if (done) begin
            state_d  = S_MAIN_GREEN;
            load     = 1'b1;
            load_val = LD_GREEN;
          end
        end
`ifdef SEMAFORO_NIGHT_BLINK_EN
        S_BLINK: begin
          state_d  = S_ALL_RED2;
          load     = 1'b1;
          load_val = LD_ALLRED;
        end
`endif
        default: begin
          state_d  = S_ALL_RED2;
          load     = 1'b1;
          load_val = LD_ALLRED;
        end
      endcase
    end
  end

`ifdef SEMAFORO_NIGHT_BLINK_EN
  // Phase is forced to YELLOW on the cycle S_BLINK is entered.
  always_comb begin
    blink_d = 1'b0;
    if (state_q == S_BLINK) begin
      blink_d = blink_q ^ tick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ALL_RED2;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    light_main = LIGHT_RED;
    light_aux  = LIGHT_RED;
    case (state_q)
      S_OFF: begin
        light_main = LIGHT_OFF;
        light_aux  = LIGHT_OFF;
      end
      S_MAIN_GREEN:  light_main = LIGHT_GREEN;
      S_MAIN_YELLOW: light_main = LIGHT_YELLOW;
      S_AUX_GREEN:   light_aux  = LIGHT_GREEN;
`ifdef SEMAFORO_NIGHT_BLINK_EN
      S_BLINK: begin
        light_main = blink_q ? LIGHT_OFF : LIGHT_YELLOW;
        light_aux  = LIGHT_OFF;
      end
`endif
      default: begin
        light_main = LIGHT_RED;
        light_aux  = LIGHT_RED;
      end
    endcase
  end

  assign ped_wait = ped_pending_q;

endmodule : semaforo_ctrl

`default_nettype wire
